// File: rtl/neuron_integrate_fire_256.sv
// neuron_integrate_fire_256
// Integrate-and-fire compute stage for one neuron. It scans NUM_AXONS axons,
// one per cycle, and adds the selected weight for every spiking, connected axon
// into a saturating accumulator. It then adds the leak, runs the threshold
// compare, and writes the new potential back to the parameter store.
// Optional build macro: NEURON_SPIKE_COUNT_EN adds a saturating fire counter
// output, spike_count_o.
module neuron_integrate_fire_256 #(
    parameter int NUM_AXONS = 256,
    parameter int ACC_W     = 16
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   start_i,
    input  logic [NUM_AXONS-1:0]   spikes_i,
    input  logic [NUM_AXONS-1:0]   connect_i,
    input  logic [2*NUM_AXONS-1:0] axon_type_i,
    input  logic [7:0]             voltage_potential_i,
    input  logic [7:0]             pos_threshold_i,
    input  logic [7:0]             neg_threshold_i,
    input  logic [7:0]             leak_value_i,
    input  logic [7:0]             weight_type1_i,
    input  logic [7:0]             weight_type2_i,
    input  logic [7:0]             weight_type3_i,
    input  logic [7:0]             weight_type4_i,
    input  logic [7:0]             pos_reset_i,
    input  logic [7:0]             neg_reset_i,
    input  logic                   wb_busy_i,
    output logic [7:0]             ext_voltage_potential_o,
    output logic                   ext_write_enable_o,
    output logic                   spike_o,
    output logic                   busy_o,
    output logic                   done_o
`ifdef NEURON_SPIKE_COUNT_EN
    ,output logic [15:0]           spike_count_o
`endif
);

    localparam int IDX_W = $clog2(NUM_AXONS);
    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_AXONS - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] C_P127   = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] C_M128   = ~C_P127;

    typedef enum logic [2:0] {S_IDLE, S_INTEG, S_LEAK, S_FIRE, S_WB} state_t;

    state_t                  r_state, w_next;
    logic signed [ACC_W-1:0] r_acc;
    logic [IDX_W-1:0]        r_idx;
    logic [7:0]              r_new;
    logic [7:0]              r_ext_v;
    logic                    r_we, r_done, r_spike;

    logic [1:0]              w_type;
    logic [7:0]              w_weight;
    logic                    w_hit;
    logic signed [ACC_W-1:0] w_pos, w_negmag, w_neg;
    logic [7:0]              w_sat8;

    // Add a sign-extended byte to the accumulator; clamp to the ACC_W limits instead of wrapping.
    function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                        input logic [7:0] b);
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {{(ACC_W-7){b[7]}}, b};
        if (s[ACC_W] != s[ACC_W-1])
            sat_add = s[ACC_W] ? ACC_MIN : ACC_MAX;
        else
            sat_add = s[ACC_W-1:0];
    endfunction

    assign w_type   = axon_type_i[{r_idx, 1'b0} +: 2];
    assign w_hit    = spikes_i[r_idx] & connect_i[r_idx];
    assign w_pos    = {{(ACC_W-8){pos_threshold_i[7]}}, pos_threshold_i};
    assign w_negmag = {{(ACC_W-8){1'b0}}, neg_threshold_i};
    assign w_neg    = -w_negmag;

    // Weight mux and 8-bit clamp of the accumulator for the no-fire path.
    always_comb begin
        w_weight = weight_type1_i;
        case (w_type)
            2'd0: w_weight = weight_type1_i;
            2'd1: w_weight = weight_type2_i;
            2'd2: w_weight = weight_type3_i;
            2'd3: w_weight = weight_type4_i;
            default: w_weight = weight_type1_i;
        endcase
        w_sat8 = r_acc[7:0];
        if (r_acc > C_P127)
            w_sat8 = 8'h7F;
        else if (r_acc < C_M128)
            w_sat8 = 8'h80;
    end

    // State register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic: fixed-length scan, then leak, fire, and a writeback that waits for the bus.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_next = S_INTEG;
            S_INTEG: if (r_idx == LAST_IDX) w_next = S_LEAK;
            S_LEAK:  w_next = S_FIRE;
            S_FIRE:  w_next = S_WB;
            S_WB:    if (!wb_busy_i) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: accumulator, scan index, fire decision and registered writeback strobes.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_acc   <= '0;
            r_idx   <= '0;
            r_new   <= '0;
            r_ext_v <= '0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            r_spike <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (start_i) begin
                    r_acc <= {{(ACC_W-8){voltage_potential_i[7]}}, voltage_potential_i};
                    r_idx <= '0;
                end
                S_INTEG: begin
                    if (w_hit) r_acc <= sat_add(r_acc, w_weight);
                    r_idx <= r_idx + 1'b1;
                end
                S_LEAK: r_acc <= sat_add(r_acc, leak_value_i);
                S_FIRE: begin
                    if (r_acc >= w_pos) begin
                        r_spike <= 1'b1;
                        r_new   <= pos_reset_i;
                    end else if (r_acc < w_neg) begin
                        r_spike <= 1'b0;
                        r_new   <= neg_reset_i;
                    end else begin
                        r_spike <= 1'b0;
                        r_new   <= w_sat8;
                    end
                end
                S_WB: if (!wb_busy_i) begin
                    r_we    <= 1'b1;
                    r_done  <= 1'b1;
                    r_ext_v <= r_new;
                end
                default: ;
            endcase
        end
    end

`ifdef NEURON_SPIKE_COUNT_EN
    logic [15:0] r_spike_cnt;

    // Count fires; sticks at all-ones, cleared only by reset.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            r_spike_cnt <= '0;
        else if (r_state == S_FIRE && r_acc >= w_pos && r_spike_cnt != 16'hFFFF)
            r_spike_cnt <= r_spike_cnt + 16'd1;
    end

    assign spike_count_o = r_spike_cnt;
`endif

    assign ext_voltage_potential_o = r_ext_v;
    assign ext_write_enable_o      = r_we;
    assign done_o                  = r_done;
    assign spike_o                 = r_spike;
    assign busy_o                  = (r_state != S_IDLE);

endmodule
